// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and default sizes for the program-counter unit
package pc_pkg;

   // Next-address source selected by PC_MUX_SEL when PC_LD is asserted
   typedef enum logic [1:0] {
      PC_SRC_IMMED = 2'b00,
      PC_SRC_STACK = 2'b01,
      PC_SRC_INTR  = 2'b10,
      PC_SRC_RSTV  = 2'b11
   } pc_src_t;

   localparam int PC_ADDR_W_DEF      = 10;
   localparam int PC_STACK_DEPTH_DEF = 8;

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - hardware LIFO of return addresses indexed by occupancy level
module ret_stack
   import pc_pkg::*;
#(
   parameter int ADDR_W      = PC_ADDR_W_DEF,
   parameter int STACK_DEPTH = PC_STACK_DEPTH_DEF
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic                               i_push,
   input  logic                               i_pop,
   input  logic [ADDR_W-1:0]                  i_din,
   output logic [ADDR_W-1:0]                  o_dout,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   o_level,
   output logic                               o_full,
   output logic                               o_empty,
   output logic                               o_ovf,
   output logic                               o_unf
);

   localparam int LVL_W = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = $clog2(STACK_DEPTH);

   logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
   logic [LVL_W-1:0]  r_level;

   logic              w_full;
   logic              w_empty;
   logic              w_do_push;
   logic              w_do_pop;
   logic [IDX_W-1:0]  w_wr_idx;
   logic [IDX_W-1:0]  w_rd_idx;

   assign w_full    = (r_level == LVL_W'(STACK_DEPTH));
   assign w_empty   = (r_level == '0);
   // A push into a full stack or a pop from an empty one is refused here;
   // the caller sees it through the ovf/unf pulses.
   assign w_do_push = i_push && !w_full;
   assign w_do_pop  = i_pop && !w_empty;

   // The write slot is entry[level]; level < depth whenever a write is allowed,
   // so the truncation to the index width is lossless.
   assign w_wr_idx  = IDX_W'(r_level);
   assign w_rd_idx  = IDX_W'(r_level - LVL_W'(1));

   // Occupancy counter; push and pop are never requested together by the top
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_level <= '0;
      end else if (w_do_push) begin
         r_level <= r_level + LVL_W'(1);
      end else if (w_do_pop) begin
         r_level <= r_level - LVL_W'(1);
      end
   end

   // Entry storage; contents are meaningless after reset so no clear is needed
   always_ff @(posedge i_clk) begin
      if (!i_rst && w_do_push) begin
         r_mem[w_wr_idx] <= i_din;
      end
   end

   assign o_dout  = r_mem[w_rd_idx];
   assign o_level = r_level;
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_ovf   = i_push && w_full;
   assign o_unf   = i_pop && w_empty;

endmodule

// File: rtl/pc_seq_unit.sv
// rtl/pc_seq_unit.sv - program counter with next-address mux and return stack
module pc_seq_unit
   import pc_pkg::*;
#(
   parameter int                ADDR_W      = PC_ADDR_W_DEF,
   parameter int                STACK_DEPTH = PC_STACK_DEPTH_DEF,
   parameter logic [ADDR_W-1:0] INTR_VEC    = {ADDR_W{1'b1}},
   parameter logic [ADDR_W-1:0] RST_VEC     = {ADDR_W{1'b0}}
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic                               PC_LD,
   input  logic                               PC_INC,
   input  logic [1:0]                         PC_MUX_SEL,
   input  logic [ADDR_W-1:0]                  FROM_IMMED,
   input  logic                               PUSH,
   output logic [ADDR_W-1:0]                  PC_COUNT,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   STACK_LEVEL,
   output logic                               STACK_FULL,
   output logic                               STACK_EMPTY,
   output logic                               STACK_ERR
);

   localparam int LVL_W = $clog2(STACK_DEPTH + 1);

   logic [ADDR_W-1:0] r_pc;
   logic              r_err;

   pc_src_t           w_sel;
   logic [ADDR_W-1:0] w_pc_plus1;
   logic [ADDR_W-1:0] w_pc_next;
   logic              w_pop;
   logic              w_push;
   logic [ADDR_W-1:0] w_stack_dout;
   logic [LVL_W-1:0]  w_level;
   logic              w_full;
   logic              w_empty;
   logic              w_ovf;
   logic              w_unf;

   assign w_sel      = pc_src_t'(PC_MUX_SEL);
   assign w_pc_plus1 = r_pc + ADDR_W'(1);

   // A pop is any load from the stack source. A push rides along with a load
   // from any other source; PUSH on a pop cycle is silently ignored.
   assign w_pop  = PC_LD && (w_sel == PC_SRC_STACK);
   assign w_push = PC_LD && PUSH && (w_sel != PC_SRC_STACK);

   ret_stack #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_ret_stack (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (w_pc_plus1),
      .o_dout  (w_stack_dout),
      .o_level (w_level),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_ovf   (w_ovf),
      .o_unf   (w_unf)
   );

   // Next-address selection: load beats increment, which beats hold
   always_comb begin
      w_pc_next = r_pc;
      if (PC_LD) begin
         case (w_sel)
            PC_SRC_IMMED: w_pc_next = FROM_IMMED;
            PC_SRC_STACK: w_pc_next = w_empty ? r_pc : w_stack_dout;
            PC_SRC_INTR:  w_pc_next = INTR_VEC;
            PC_SRC_RSTV:  w_pc_next = RST_VEC;
         endcase
      end else if (PC_INC) begin
         w_pc_next = w_pc_plus1;
      end
   end

   // PC register; reset overrides every other request
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pc <= RST_VEC;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   // Sticky stack error: set by any refused push or pop, cleared only by reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_err <= 1'b0;
      end else if (w_ovf || w_unf) begin
         r_err <= 1'b1;
      end
   end

   assign PC_COUNT    = r_pc;
   assign STACK_LEVEL = w_level;
   assign STACK_FULL  = w_full;
   assign STACK_EMPTY = w_empty;
   assign STACK_ERR   = r_err;

endmodule

// File: tb/tb_pc_seq_unit.sv
// tb/tb_pc_seq_unit.sv - scoreboard bench for pc_seq_unit against a queue-based model
module tb_pc_seq_unit;

   localparam int AW    = 10;
   localparam int DEPTH = 8;
   localparam int AMOD  = 1 << AW;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          PC_LD = 1'b0;
   logic          PC_INC = 1'b0;
   logic [1:0]    PC_MUX_SEL = 2'b00;
   logic [AW-1:0] FROM_IMMED = '0;
   logic          PUSH = 1'b0;
   logic [AW-1:0] PC_COUNT;
   logic [3:0]    STACK_LEVEL;
   logic          STACK_FULL;
   logic          STACK_EMPTY;
   logic          STACK_ERR;

   pc_seq_unit dut (
      .CLK         (CLK),
      .RST         (RST),
      .PC_LD       (PC_LD),
      .PC_INC      (PC_INC),
      .PC_MUX_SEL  (PC_MUX_SEL),
      .FROM_IMMED  (FROM_IMMED),
      .PUSH        (PUSH),
      .PC_COUNT    (PC_COUNT),
      .STACK_LEVEL (STACK_LEVEL),
      .STACK_FULL  (STACK_FULL),
      .STACK_EMPTY (STACK_EMPTY),
      .STACK_ERR   (STACK_ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [3:0]    lvl;
      logic          full;
      logic          empty;
      logic          err;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int m_pc  = 0;
   int m_stk[$];
   bit m_err = 1'b0;

   task automatic model_step(input bit rst, input bit ld, input bit inc,
                             input int sel, input int imm, input bit push);
      int ret_addr;
      ret_addr = (m_pc + 1) % AMOD;
      if (rst) begin
         m_pc  = 0;
         m_stk.delete();
         m_err = 1'b0;
      end else if (ld) begin
         if (sel == 1) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else                  m_err = 1'b1;
         end else begin
            if (push) begin
               if (m_stk.size() == DEPTH) m_err = 1'b1;
               else                       m_stk.push_back(ret_addr);
            end
            if (sel == 0)      m_pc = imm;
            else if (sel == 2) m_pc = AMOD - 1;
            else               m_pc = 0;
         end
      end else if (inc) begin
         m_pc = ret_addr;
      end
   endtask

   task automatic step(input bit rst, input bit ld, input bit inc,
                       input int sel, input int imm, input bit push);
      exp_t e;
      RST        = rst;
      PC_LD      = ld;
      PC_INC     = inc;
      PC_MUX_SEL = sel[1:0];
      FROM_IMMED = imm[AW-1:0];
      PUSH       = push;
      model_step(rst, ld, inc, sel, imm, push);
      e.pc    = m_pc[AW-1:0];
      e.lvl   = 4'(m_stk.size());
      e.full  = (m_stk.size() == DEPTH);
      e.empty = (m_stk.size() == 0);
      e.err   = m_err;
      @(posedge CLK);
      exp_q.push_back(e);
      #1;
   endtask

   task automatic call(input int target);
      step(0, 1, 0, 0, target, 1);
   endtask

   task automatic ret();
      step(0, 1, 0, 1, 0, 0);
   endtask

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
   endtask

   // monitor: outputs are registered, so every cycle presents a fresh response
   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("pc_count",    int'(PC_COUNT),    int'(e.pc));
         chk("stack_level", int'(STACK_LEVEL), int'(e.lvl));
         chk("stack_full",  int'(STACK_FULL),  int'(e.full));
         chk("stack_empty", int'(STACK_EMPTY), int'(e.empty));
         chk("stack_err",   int'(STACK_ERR),   int'(e.err));
      end
   end

   initial begin
      // 1: reset, increment, wrap
      step(1, 0, 0, 0, 0, 0);
      repeat (3) step(0, 0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 'h3FF, 0);
      step(0, 0, 1, 0, 0, 0);

      // 2: call / return
      step(0, 1, 0, 0, 'h010, 0);
      call('h120);
      ret();

      // 3: nested calls to overflow, then LIFO unwind
      step(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < DEPTH; k++) call(k + 1);
      call('h200);
      for (int k = 0; k < DEPTH; k++) ret();

      // 4: underflow is sticky until reset
      step(1, 0, 0, 0, 0, 0);
      ret();
      repeat (3) step(0, 0, 1, 0, 0, 0);
      step(0, 1, 0, 3, 0, 0);
      step(1, 0, 0, 0, 0, 0);

      // 5: interrupt entry pushes PC+1, return resumes there
      step(0, 1, 0, 0, 'h055, 0);
      step(0, 1, 0, 2, 0, 1);
      ret();

      // 6: priority and push qualification
      step(0, 1, 1, 0, 'h0AA, 0);
      call('h100);
      step(1, 1, 0, 0, 'h155, 1);
      call('h0C0);
      step(0, 0, 1, 0, 0, 1);
      step(0, 1, 0, 1, 0, 1);
      step(0, 1, 0, 3, 0, 1);

      // randomized traffic; pops are biased so the stack both fills and drains
      for (int i = 0; i < 3000; i++) begin
         bit rst_r, ld_r, inc_r, push_r;
         int sel_r;
         rst_r  = ($urandom_range(0, 99) == 0);
         ld_r   = ($urandom_range(0, 2) != 0);
         inc_r  = $urandom_range(0, 1);
         push_r = $urandom_range(0, 1);
         sel_r  = $urandom_range(0, 3);
         step(rst_r, ld_r, inc_r, sel_r, $urandom_range(0, AMOD - 1), push_r);
      end

      step(0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge CLK);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
Parametrised program-counter unit for the RAT CPU. It holds the PC register and selects the next address from four sources: immediate, internal return stack, interrupt vector, or reset vector. It supports increment, and contains a hardware LIFO return-address stack for CALL/RET/interrupt with overflow and underflow detection. It sits between the control unit and the program ROM address input.

Parameters:
ADDR_W, 10, PC and address width in bits
STACK_DEPTH, 8, number of return-stack entries (>=2)
INTR_VEC, {ADDR_W{1'b1}}, address loaded for PC_MUX_SEL=2'b10
RST_VEC, {ADDR_W{1'b0}}, PC value at reset and address loaded for PC_MUX_SEL=2'b11

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous active-high reset
PC_LD  input  1  load PC from the source selected by PC_MUX_SEL
PC_INC  input  1  PC <= PC+1 (ignored when PC_LD=1)
PC_MUX_SEL  input  2  00 immed, 01 stack pop, 10 INTR_VEC, 11 RST_VEC
FROM_IMMED  input  ADDR_W  immediate branch/call target
PUSH  input  1  push PC_COUNT+1 onto the return stack; qualified by PC_LD
PC_COUNT  output  ADDR_W  current PC
STACK_LEVEL  output  $clog2(STACK_DEPTH+1)  number of occupied entries
STACK_FULL  output  1  STACK_LEVEL==STACK_DEPTH
STACK_EMPTY  output  1  STACK_LEVEL==0
STACK_ERR  output  1  sticky overflow/underflow flag

Behaviour:
- All state updates on the rising edge of CLK. One clock; reset is synchronous and active-high (RST).
- Reset values: PC_COUNT=RST_VEC; STACK_LEVEL=0; STACK_EMPTY=1; STACK_FULL=0; STACK_ERR=0. Stack contents are don't-care after reset.
- Priority: RST > PC_LD > PC_INC > hold.
- PC_INC: PC_COUNT <= PC_COUNT+1, modulo 2^ADDR_W. The maximum address wraps to 0.
- PC_LD with PC_MUX_SEL:
  - 00: PC_COUNT <= FROM_IMMED.
  - 01: pop. If not empty, PC_COUNT <= top entry and STACK_LEVEL decrements. If empty, PC_COUNT holds, the level stays 0, and STACK_ERR is set.
  - 10: PC_COUNT <= INTR_VEC.
  - 11: PC_COUNT <= RST_VEC. The stack is not cleared.
- Push:
  - Acts only when PUSH=1, PC_LD=1 and PC_MUX_SEL!=01.
  - The pushed value is PC_COUNT+1 (wrapping), sampled before the edge.
  - If the stack is full, the push is dropped, STACK_ERR is set, and the PC load still occurs.
- PUSH with PC_LD=0 is ignored, with no error.
- PUSH together with a pop (sel 01) is ignored. The pop proceeds and no error is raised.
- Latency: a new PC_COUNT appears the cycle after the edge, with no combinational path from inputs to PC_COUNT. A popped address is valid on the same edge as the level decrement.
- STACK_FULL and STACK_EMPTY are derived combinationally from the registered level. STACK_ERR clears only on RST.
- Stack is a LIFO indexed by level: push writes entry[level]; pop reads entry[level-1].

Decomposition:
- Shared package pc_pkg:
  - typedef enum logic [1:0] pc_src_t {PC_SRC_IMMED=2'b00, PC_SRC_STACK=2'b01, PC_SRC_INTR=2'b10, PC_SRC_RSTV=2'b11}.
  - Default ADDR_W and STACK_DEPTH localparams.
- Sub-module ret_stack (parameters ADDR_W, STACK_DEPTH):
  - Inputs: push, pop, din.
  - Outputs: dout, level, full, empty, ovf/unf pulses.
- pc_seq_unit owns the PC register, next-address mux and sticky error flag.

Test Plan:
1. RST=1 for one cycle, then PC_INC=1 for 3 cycles -> PC_COUNT 0x000, 0x001, 0x002, 0x003. Load 0x3FF, then PC_INC -> 0x000 (wrap).
2. CALL: PC_COUNT=0x010, PC_LD=1, sel=00, FROM_IMMED=0x120, PUSH=1 -> PC_COUNT=0x120, STACK_LEVEL=1. RET: PC_LD=1, sel=01 -> PC_COUNT=0x011, STACK_LEVEL=0, STACK_EMPTY=1.
3. Nested: 8 CALLs from PCs 0x000..0x007 -> STACK_FULL=1. A 9th CALL to 0x200 -> PC_COUNT=0x200, level stays 8, STACK_ERR=1. Eight RETs -> 0x008, 0x007, ..., 0x001 (LIFO order).
4. Underflow: after reset, PC_LD=1, sel=01 -> PC_COUNT holds 0x000, STACK_ERR=1, and STACK_ERR persists until the next RST.
5. Interrupt: PC_COUNT=0x055, PC_LD=1, sel=10, PUSH=1 -> PC_COUNT=0x3FF, top entry=0x056. RET -> 0x056.
6. Priority: PC_LD=1, sel=00, FROM_IMMED=0x0AA, PC_INC=1 -> 0x0AA. RST asserted with PC_LD and PUSH -> PC_COUNT=0x000, level 0. PUSH with PC_LD=0 -> level unchanged.
